// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage. Holds the program counter (F_PC), which drives the
// word-addressed instruction memory. The returned instruction is captured into
// the fetch/decode register (D_Instr, D_PC, D_Valid). The stage handles stall,
// branch redirect with decode flush, and a sticky halt. It also keeps a
// saturating count of instructions delivered to decode.
//
// Ports:
//   clk        in   clock, rising-edge
//   reset      in   asynchronous active-high reset
//   Stall      in   decode cannot accept; hold PC and decode register
//   Redirect   in   load RedirectPC into F_PC and flush decode register
//   RedirectPC in   redirect target (word address)
//   Halt       in   stop fetching; sticky until reset
//   Instr      in   instruction from memory at F_PC (combinational)
//   F_PC       out  registered PC to instruction memory
//   D_Instr    out  registered instruction for decode
//   D_PC       out  address D_Instr was fetched from
//   D_Valid    out  decode register holds a live instruction
//   Halted     out  stage is in HALTED state
//   FetchCount out  saturating count of instructions delivered to decode
module fetch_stage #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Stall,
  input  logic                   Redirect,
  input  logic [ADDR_WIDTH-1:0]  RedirectPC,
  input  logic                   Halt,
  input  logic [INSTR_WIDTH-1:0] Instr,
  output logic [ADDR_WIDTH-1:0]  F_PC,
  output logic [INSTR_WIDTH-1:0] D_Instr,
  output logic [ADDR_WIDTH-1:0]  D_PC,
  output logic                   D_Valid,
  output logic                   Halted,
  output logic [COUNT_WIDTH-1:0] FetchCount
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  state_t                 state_r,   state_next;
  logic [ADDR_WIDTH-1:0]  f_pc_r,    f_pc_next;
  logic [INSTR_WIDTH-1:0] d_instr_r, d_instr_next;
  logic [ADDR_WIDTH-1:0]  d_pc_r,    d_pc_next;
  logic                   d_valid_r, d_valid_next;
  logic [COUNT_WIDTH-1:0] count_r,   count_next;

  // State and pipeline registers, asynchronously cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= RUN;
      f_pc_r    <= RESET_PC;
      d_instr_r <= {INSTR_WIDTH{1'b0}};
      d_pc_r    <= {ADDR_WIDTH{1'b0}};
      d_valid_r <= 1'b0;
      count_r   <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_r   <= state_next;
      f_pc_r    <= f_pc_next;
      d_instr_r <= d_instr_next;
      d_pc_r    <= d_pc_next;
      d_valid_r <= d_valid_next;
      count_r   <= count_next;
    end
  end

  // Next-state logic: halt > redirect > stall > advance while running.
  always_comb begin
    state_next   = state_r;
    f_pc_next    = f_pc_r;
    d_instr_next = d_instr_r;
    d_pc_next    = d_pc_r;
    d_valid_next = d_valid_r;
    count_next   = count_r;
    case (state_r)
      RUN: begin
        if (Halt) begin
          // Instruction sitting in decode is discarded; its fields stay put.
          state_next   = HALTED;
          d_valid_next = 1'b0;
        end else if (Redirect) begin
          // Flush wins over Stall: the decode slot is dead either way.
          f_pc_next    = RedirectPC;
          d_valid_next = 1'b0;
        end else if (Stall) begin
          f_pc_next    = f_pc_r;
          d_valid_next = d_valid_r;
        end else begin
          d_instr_next = Instr;
          d_pc_next    = f_pc_r;
          d_valid_next = 1'b1;
          // PC wraps modulo 2^ADDR_WIDTH by plain truncation.
          f_pc_next    = f_pc_r + ADDR_WIDTH'(1);
          if (count_r != COUNT_MAX) begin
            count_next = count_r + COUNT_WIDTH'(1);
          end else begin
            count_next = count_r;
          end
        end
      end
      HALTED: begin
        state_next   = HALTED;
        d_valid_next = 1'b0;
      end
      default: begin
        // Unreachable encoding: park safely in HALTED with decode invalid.
        state_next   = HALTED;
        d_valid_next = 1'b0;
      end
    endcase
  end

  assign F_PC       = f_pc_r;
  assign D_Instr    = d_instr_r;
  assign D_PC       = d_pc_r;
  assign D_Valid    = d_valid_r;
  assign Halted     = (state_r == HALTED);
  assign FetchCount = count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios from the test plan
// plus a randomized run checked against a behavioural model of the stage.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic        Halt;
  logic [31:0] Instr;
  logic [15:0] F_PC;
  logic [31:0] D_Instr;
  logic [15:0] D_PC;
  logic        D_Valid;
  logic        Halted;
  logic [3:0]  FetchCount;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_key = 32'h0000_0000;

  // Behavioural model state
  logic [15:0] m_fpc;
  logic [31:0] m_dinstr;
  logic [15:0] m_dpc;
  logic        m_dvalid;
  logic        m_halted;
  int          m_count;

  fetch_stage #(
    .ADDR_WIDTH (16),
    .INSTR_WIDTH(32),
    .RESET_PC   (16'h0000),
    .COUNT_WIDTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Stall     (Stall),
    .Redirect  (Redirect),
    .RedirectPC(RedirectPC),
    .Halt      (Halt),
    .Instr     (Instr),
    .F_PC      (F_PC),
    .D_Instr   (D_Instr),
    .D_PC      (D_PC),
    .D_Valid   (D_Valid),
    .Halted    (Halted),
    .FetchCount(FetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return mem_key ^ (32'h1000_0000 + {16'h0000, a});
  endfunction

  // Instruction memory: combinational read at the fetch address.
  assign Instr = mem_word(F_PC);

  task automatic model_reset();
    m_fpc    = 16'h0000;
    m_dinstr = 32'h0;
    m_dpc    = 16'h0000;
    m_dvalid = 1'b0;
    m_halted = 1'b0;
    m_count  = 0;
  endtask

  // Assert reset between edges, clear the model, release away from an edge.
  task automatic do_reset();
    Halt = 1'b0; Redirect = 1'b0; Stall = 1'b0; RedirectPC = 16'h0000;
    reset = 1'b1;
    model_reset();
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
  endtask

  // Drive one cycle of inputs, advance the model by the stage rules, and
  // return #1 after the rising edge.
  task automatic cycle(input logic h, input logic r, input logic [15:0] rpc,
                       input logic s);
    Halt = h; Redirect = r; RedirectPC = rpc; Stall = s;
    if (!m_halted) begin
      if (h) begin
        m_halted = 1'b1;
        m_dvalid = 1'b0;
      end else if (r) begin
        m_fpc    = rpc;
        m_dvalid = 1'b0;
      end else if (!s) begin
        m_dinstr = mem_word(m_fpc);
        m_dpc    = m_fpc;
        m_dvalid = 1'b1;
        m_fpc    = m_fpc + 16'd1;
        if (m_count < 15) m_count = m_count + 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Halt = 1'b0; Redirect = 1'b0; Stall = 1'b0; RedirectPC = 16'h0000;
    model_reset();
    #1;
    total++;
    if ({F_PC, D_Instr, D_PC, D_Valid, Halted, FetchCount} !== {16'h0, 32'h0, 16'h0, 1'b0, 1'b0, 4'h0}) begin
      bad++;
      $display("FAIL reset_state: got F_PC=%h D_Instr=%h D_PC=%h D_Valid=%b Halted=%b Cnt=%0d, want all zero",
               F_PC, D_Instr, D_PC, D_Valid, Halted, FetchCount);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_free_run();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      total++;
      if (D_Instr !== 32'h1000_0000 + i || D_PC !== 16'(i) || D_Valid !== 1'b1) begin
        bad++;
        $display("FAIL free_run[%0d]: got D_Instr=%h D_PC=%h D_Valid=%b, want %h %h 1",
                 i, D_Instr, D_PC, D_Valid, 32'h1000_0000 + i, 16'(i));
      end
    end
    total++;
    if (FetchCount !== 4'd4 || F_PC !== 16'd4) begin
      bad++;
      $display("FAIL free_run_count: got Cnt=%0d F_PC=%h, want 4 0004", FetchCount, F_PC);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      total++;
      if (D_PC !== 16'd2 || D_Instr !== 32'h1000_0002 || D_Valid !== 1'b1 ||
          F_PC !== 16'd3 || FetchCount !== 4'd3) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got D_PC=%h D_Instr=%h V=%b F_PC=%h Cnt=%0d, want 0002 10000002 1 0003 3",
                 k, D_PC, D_Instr, D_Valid, F_PC, FetchCount);
      end
    end
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    total++;
    if (D_PC !== 16'd3 || D_Instr !== 32'h1000_0003 || FetchCount !== 4'd4) begin
      bad++;
      $display("FAIL stall_release: got D_PC=%h D_Instr=%h Cnt=%0d, want 0003 10000003 4",
               D_PC, D_Instr, FetchCount);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 16'h0040, 1'b1);
    total++;
    if (F_PC !== 16'h0040 || D_Valid !== 1'b0) begin
      bad++;
      $display("FAIL redirect_flush: got F_PC=%h D_Valid=%b, want 0040 0", F_PC, D_Valid);
    end
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    total++;
    if (D_PC !== 16'h0040 || D_Valid !== 1'b1 || D_Instr !== 32'h1000_0040) begin
      bad++;
      $display("FAIL redirect_fetch: got D_PC=%h V=%b D_Instr=%h, want 0040 1 10000040",
               D_PC, D_Valid, D_Instr);
    end
    // Redirect to the current PC still flushes.
    cycle(1'b0, 1'b1, F_PC, 1'b0);
    total++;
    if (F_PC !== 16'h0041 || D_Valid !== 1'b0) begin
      bad++;
      $display("FAIL redirect_same: got F_PC=%h D_Valid=%b, want 0041 0", F_PC, D_Valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(1'b0, 1'b1, 16'hFFFF, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    total++;
    if (D_PC !== 16'hFFFF || D_Instr !== 32'h1000_FFFF || F_PC !== 16'h0000) begin
      bad++;
      $display("FAIL wrap_first: got D_PC=%h D_Instr=%h F_PC=%h, want FFFF 1000ffff 0000",
               D_PC, D_Instr, F_PC);
    end
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    total++;
    if (D_PC !== 16'h0000 || F_PC !== 16'h0001 || D_Valid !== 1'b1) begin
      bad++;
      $display("FAIL wrap_second: got D_PC=%h F_PC=%h V=%b, want 0000 0001 1", D_PC, F_PC, D_Valid);
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    total++;
    if (Halted !== 1'b1 || D_Valid !== 1'b0 || F_PC !== 16'd3 || FetchCount !== 4'd3) begin
      bad++;
      $display("FAIL halt_enter: got Halted=%b V=%b F_PC=%h Cnt=%0d, want 1 0 0003 3",
               Halted, D_Valid, F_PC, FetchCount);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, i[0], 16'h0123, i[1]);
      total++;
      if (Halted !== 1'b1 || D_Valid !== 1'b0 || F_PC !== 16'd3 || FetchCount !== 4'd3) begin
        bad++;
        $display("FAIL halt_frozen[%0d]: got Halted=%b V=%b F_PC=%h Cnt=%0d, want 1 0 0003 3",
                 i, Halted, D_Valid, F_PC, FetchCount);
      end
    end
    do_reset();
    total++;
    if (Halted !== 1'b0 || F_PC !== 16'h0000 || FetchCount !== 4'd0) begin
      bad++;
      $display("FAIL halt_reset: got Halted=%b F_PC=%h Cnt=%0d, want 0 0000 0", Halted, F_PC, FetchCount);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    total++;
    if ({F_PC, D_Instr, D_PC, D_Valid, Halted, FetchCount} !== {16'h0, 32'h0, 16'h0, 1'b0, 1'b0, 4'h0}) begin
      bad++;
      $display("FAIL async_reset: got F_PC=%h D_Instr=%h D_PC=%h V=%b Halted=%b Cnt=%0d, want all zero",
               F_PC, D_Instr, D_PC, D_Valid, Halted, FetchCount);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_random();
    logic h, r, s;
    logic [15:0] rpc;
    mem_key = $urandom;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (m_halted && $urandom_range(0, 7) == 0) do_reset();
      h   = ($urandom_range(0, 79) == 0);
      r   = ($urandom_range(0, 4) == 0);
      s   = ($urandom_range(0, 3) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom);
      cycle(h, r, rpc, s);
      total++;
      if (F_PC !== m_fpc || D_PC !== m_dpc || D_Valid !== m_dvalid || Halted !== m_halted ||
          FetchCount !== 4'(m_count) || D_Instr !== m_dinstr) begin
        bad++;
        $display("FAIL random[%0d]: got F_PC=%h D_PC=%h D_Instr=%h V=%b H=%b Cnt=%0d, want %h %h %h %b %b %0d",
                 n, F_PC, D_PC, D_Instr, D_Valid, Halted, FetchCount,
                 m_fpc, m_dpc, m_dinstr, m_dvalid, m_halted, m_count);
      end
    end
    mem_key = 32'h0000_0000;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_wrap();
    test_halt();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
